// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// The grant is combinational; the winning address/data/enable are registered one cycle later.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter bit DROP_R0    = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [5*NUM_REQ-1:0]          reqAddr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqAck,
    output logic                          wrEnable,
    output logic [4:0]                    wrAddr,
    output logic [DATA_WIDTH-1:0]         wrData,
    output logic [2:0]                    lastGrant
);

    localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

    // Requesters are widened to 8 slots so a 3-bit index never selects out of range.
    logic [7:0]            validPad;
    logic [4:0]            addrArr [8];
    logic [DATA_WIDTH-1:0] dataArr [8];

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : gUnpack
            if (i < NUM_REQ) begin : gLive
                assign validPad[i] = reqValid[i];
                assign addrArr[i]  = reqAddr[5*i +: 5];
                assign dataArr[i]  = reqData[DATA_WIDTH*i +: DATA_WIDTH];
            end else begin : gTie
                assign validPad[i] = 1'b0;
                assign addrArr[i]  = 5'd0;
                assign dataArr[i]  = '0;
            end
        end
    endgenerate

    logic [2:0] ptr;
    logic [2:0] winner;
    logic [2:0] nextPtr;
    logic [3:0] idx;
    logic       found;
    logic       grant;

    // Scan from the pointer upward, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ))
                idx = idx - 4'(NUM_REQ);
            if (!found && validPad[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    assign grant   = found & ~hold & ~reset;
    assign reqAck  = grant ? (ACK_ONE << winner) : '0;
    assign nextPtr = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrEnable  <= 1'b0;
            wrAddr    <= 5'd0;
            wrData    <= '0;
            lastGrant <= 3'd0;
            ptr       <= 3'd0;
        end else if (grant) begin
            wrAddr    <= addrArr[winner];
            wrData    <= dataArr[winner];
            lastGrant <= winner;
            ptr       <= nextPtr;
            // r0 is hardwired zero: the request is consumed but no strobe is issued.
            wrEnable  <= !(DROP_R0 && (addrArr[winner] == 5'd0));
        end else begin
            wrEnable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-free behavioural model,
// with directed sequences for reset, saturation, pointer skip, r0 drop and hold.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            hold;
    logic [N-1:0]    reqValid;
    logic [5*N-1:0]  reqAddr;
    logic [DW*N-1:0] reqData;

    logic [N-1:0]    reqAck,    reqAck1;
    logic            wrEnable,  wrEnable1;
    logic [4:0]      wrAddr,    wrAddr1;
    logic [DW-1:0]   wrData,    wrData1;
    logic [2:0]      lastGrant, lastGrant1;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DROP_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .hold(hold), .reqValid(reqValid), .reqAddr(reqAddr),
        .reqData(reqData), .reqAck(reqAck), .wrEnable(wrEnable), .wrAddr(wrAddr),
        .wrData(wrData), .lastGrant(lastGrant)
    );

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DROP_R0(1'b0)) dutKeep (
        .clk(clk), .reset(reset), .hold(hold), .reqValid(reqValid), .reqAddr(reqAddr),
        .reqData(reqData), .reqAck(reqAck1), .wrEnable(wrEnable1), .wrAddr(wrAddr1),
        .wrData(wrData1), .lastGrant(lastGrant1)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Model state: what the write port should show after the last edge.
    int mPtr, mLast, mAddr, mData;
    bit mEn, mEn1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [5*N-1:0] mkA(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic modelReset();
        mPtr = 0; mLast = 0; mAddr = 0; mData = 0; mEn = 0; mEn1 = 0;
    endtask

    task automatic checkOut();
        chk("wrEnable",   wrEnable,   mEn);
        chk("wrAddr",     wrAddr,     mAddr);
        chk("wrData",     wrData,     mData);
        chk("lastGrant",  lastGrant,  mLast);
        chk("wrEnableK",  wrEnable1,  mEn1);
        chk("wrAddrK",    wrAddr1,    mAddr);
        chk("lastGrantK", lastGrant1, mLast);
    endtask

    // Called at a negedge; drives one cycle of inputs and leaves us at the next negedge.
    task automatic step(input bit h, input logic [N-1:0] v, input logic [5*N-1:0] a,
                        input logic [DW*N-1:0] d);
        int w;
        logic [N-1:0] expAck;
        hold = h; reqValid = v; reqAddr = a; reqData = d;
        #1;
        w = h ? -1 : pick(v, mPtr);
        expAck = (w < 0) ? '0 : N'(1 << w);
        chk("reqAck",  reqAck,  expAck);
        chk("reqAckK", reqAck1, expAck);
        @(posedge clk);
        if (w >= 0) begin
            mAddr = int'(a[5*w +: 5]);
            mData = int'(d[DW*w +: DW]);
            mLast = w;
            mPtr  = (w + 1) % N;
            mEn   = (mAddr != 0);
            mEn1  = 1'b1;
        end else begin
            mEn  = 1'b0;
            mEn1 = 1'b0;
        end
        @(negedge clk);
        checkOut();
    endtask

    // Asynchronous reset pulse placed between edges; requests during reset must not be acked.
    task automatic doReset();
        #2 reset = 1'b1; hold = 1'b0; reqValid = '1;
        #1;
        modelReset();
        chk("rstAck", reqAck, '0);
        checkOut();
        reqValid = '0;
        #1 reset = 1'b0;
        @(negedge clk);
        checkOut();
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; reqValid = '0; reqAddr = '0; reqData = '0;
        modelReset();
        #12;
        checkOut();
        @(negedge clk);
        reset = 1'b0;

        // Single request and its one-cycle latency.
        step(0, 4'b0001, mkA(7, 0, 0, 0), {48'd0, 16'hBEEF});
        chk("single.en",   wrEnable, 1);
        chk("single.addr", wrAddr,   7);
        chk("single.data", wrData,   16'hBEEF);
        step(0, 4'b0000, '0, '0);
        chk("single.idle", wrEnable, 0);

        // Saturation after reset: grants 0,1,2,3,0,1.
        doReset();
        for (int k = 0; k < 6; k++) begin
            step(0, 4'b1111, mkA(1, 2, 3, 4), {16'h4444, 16'h3333, 16'h2222, 16'h1111});
            chk("sat.grant", lastGrant, k % 4);
            chk("sat.addr",  wrAddr,    k % 4 + 1);
            chk("sat.en",    wrEnable,  1);
        end

        // Pointer skip: pointer sits at 2, so 3 wins, then 0.
        step(0, 4'b1001, mkA(5, 0, 0, 6), '0);
        chk("skip.first", lastGrant, 3);
        step(0, 4'b1001, mkA(5, 0, 0, 6), '0);
        chk("skip.second", lastGrant, 0);

        // Write to r0 from requester 2: consumed but dropped on the DROP_R0 instance.
        step(0, 4'b0100, mkA(0, 0, 0, 0), {16'd0, 16'h1234, 32'd0});
        chk("r0.en",     wrEnable,  0);
        chk("r0.grant",  lastGrant, 2);
        chk("r0.keepEn", wrEnable1, 1);
        chk("r0.keepA",  wrAddr1,   0);
        step(0, 4'b1111, mkA(1, 2, 3, 4), '0);
        chk("r0.ptr", lastGrant, 3);

        // Hold: pointer advanced to 1 by a grant to 0, frozen for three cycles.
        step(0, 4'b0001, mkA(8, 9, 0, 0), '0);
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b0011, mkA(8, 9, 0, 0), '0);
            chk("hold.en", wrEnable, 0);
        end
        step(0, 4'b0011, mkA(8, 9, 0, 0), '0);
        chk("hold.release", lastGrant, 1);

        // Reset the cycle after an accept: pending write lost, pointer back to 0.
        step(0, 4'b0100, mkA(0, 0, 9, 0), {16'd0, 16'hCAFE, 32'd0});
        chk("rst.pending", wrEnable, 1);
        doReset();
        step(0, 4'b1001, mkA(3, 0, 0, 4), {16'h0004, 32'd0, 16'h0003});
        chk("rst.restart", lastGrant, 0);

        // Random traffic with occasional hold and reset.
        for (int k = 0; k < 400; k++) begin
            logic [5*N-1:0] a;
            logic [DW*N-1:0] d;
            for (int j = 0; j < N; j++) begin
                a[5*j +: 5]   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
                d[DW*j +: DW] = DW'($urandom);
            end
            if ($urandom % 40 == 0)
                doReset();
            else
                step($urandom % 4 == 0, N'($urandom), a, d);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
